// File: rtl/jpeg_bit_packer.sv
// rtl/jpeg_bit_packer.sv - MSB-first entropy code packer with 0xFF byte stuffing and 1-padded flush
module jpeg_bit_packer #(
  parameter int MAX_CODE_LEN = 16,
  parameter bit STUFF_EN     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        code_valid,
  output logic        code_ready,
  input  logic [15:0] code_bits,
  input  logic [7:0]  code_len,
  input  logic        flush_req,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [7:0]  byte_data,
  output logic        flush_done,
  output logic        err_len,
  output logic        busy
);

  typedef enum logic [1:0] {RUN, PAD, DRAIN} state_t;
  state_t state, state_next;

  logic [31:0] acc;
  logic [5:0]  acc_cnt;
  logic        stuff_pend;

  logic        accept, len_ok, len_bad, out_free;
  logic        load_stuff, load_acc, drain_done;
  logic [4:0]  len5;
  logic [2:0]  pad_len;
  logic [31:0] app_bits, merged, acc_next;
  logic [5:0]  app_len, app_shamt, merged_cnt, cnt_next;

  assign accept   = code_valid && code_ready;
  assign len_ok   = (code_len != 8'd0) && (code_len <= 8'(MAX_CODE_LEN));
  assign len_bad  = code_len > 8'(MAX_CODE_LEN);
  assign len5     = code_len[4:0];
  assign pad_len  = 3'd0 - acc_cnt[2:0];
  assign out_free = !byte_valid || byte_ready;

  // New bits (an accepted code or the flush 1-padding) land directly below the buffered ones
  always_comb begin
    app_bits = 32'd0;
    app_len  = 6'd0;
    if (accept && len_ok) begin
      app_bits = {16'd0, code_bits} & ((32'd1 << len5) - 32'd1);
      app_len  = {1'b0, len5};
    end else if (state == PAD && pad_len != 3'd0) begin
      app_bits = (32'd1 << pad_len) - 32'd1;
      app_len  = {3'd0, pad_len};
    end
  end

  assign app_shamt  = 6'd32 - acc_cnt - app_len;
  assign merged     = (app_len == 6'd0) ? acc : (acc | (app_bits << app_shamt));
  assign merged_cnt = acc_cnt + app_len;

  // Extracting from the merged word lets a byte completed this cycle appear next cycle
  assign load_stuff = out_free && stuff_pend;
  assign load_acc   = out_free && !stuff_pend && (merged_cnt >= 6'd8);
  assign acc_next   = load_acc ? {merged[23:0], 8'd0} : merged;
  assign cnt_next   = load_acc ? (merged_cnt - 6'd8) : merged_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (flush_req) state_next = PAD;
      PAD:     state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    code_ready = (state == RUN) && (acc_cnt <= 6'd16);
    drain_done = (state == DRAIN) && (acc_cnt == 6'd0) && !stuff_pend && out_free;
    busy       = (state != RUN) || (acc_cnt != 6'd0) || byte_valid;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc        <= 32'd0;
      acc_cnt    <= 6'd0;
      stuff_pend <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
      flush_done <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      acc        <= acc_next;
      acc_cnt    <= cnt_next;
      flush_done <= drain_done;
      if (accept && len_bad) begin
        err_len <= 1'b1;
      end
      if (load_stuff) begin
        byte_data  <= 8'h00;
        byte_valid <= 1'b1;
        stuff_pend <= 1'b0;
      end else if (load_acc) begin
        byte_data  <= merged[31:24];
        byte_valid <= 1'b1;
        stuff_pend <= STUFF_EN && (merged[31:24] == 8'hFF);
      end else if (out_free) begin
        byte_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// tb/tb_jpeg_bit_packer.sv - table, directed and randomized checks of jpeg_bit_packer
module tb_jpeg_bit_packer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        code_valid = 1'b0;
  logic        flush_req = 1'b0;
  logic        byte_ready = 1'b0;
  logic [15:0] code_bits = 16'd0;
  logic [7:0]  code_len = 8'd0;
  logic        code_ready, byte_valid, flush_done, err_len, busy;
  logic [7:0]  byte_data;
  logic        n_code_ready, n_byte_valid, n_flush_done, n_err_len, n_busy;
  logic [7:0]  n_byte_data;

  int errors = 0;
  int checks = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  bit         bitq[$];

  typedef struct {
    logic [15:0] bits;
    logic [7:0]  len;
    int          n;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs[10];

  always #5 clock = ~clock;

  jpeg_bit_packer #(.MAX_CODE_LEN(16), .STUFF_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .code_valid(code_valid), .code_ready(code_ready),
    .code_bits(code_bits), .code_len(code_len), .flush_req(flush_req),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .flush_done(flush_done), .err_len(err_len), .busy(busy)
  );

  jpeg_bit_packer #(.MAX_CODE_LEN(16), .STUFF_EN(1'b0)) dut_nostuff (
    .clock(clock), .reset(reset), .code_valid(code_valid), .code_ready(n_code_ready),
    .code_bits(code_bits), .code_len(code_len), .flush_req(flush_req),
    .byte_valid(n_byte_valid), .byte_ready(byte_ready), .byte_data(n_byte_data),
    .flush_done(n_flush_done), .err_len(n_err_len), .busy(n_busy)
  );

  // Reference: a plain bit queue; whole bytes leave it MSB-first, each 0xFF followed by 0x00
  function automatic void model_drain();
    logic [7:0] v;
    while (bitq.size() >= 8) begin
      v = 8'd0;
      for (int k = 0; k < 8; k++) v = {v[6:0], bitq.pop_front()};
      exp_q.push_back(v);
      if (v == 8'hFF) exp_q.push_back(8'h00);
    end
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      if (byte_valid && byte_ready) rx_q.push_back(byte_data);
      if (code_valid && code_ready && code_len >= 8'd1 && code_len <= 8'd16)
        for (int i = int'(code_len) - 1; i >= 0; i--) bitq.push_back(code_bits[i]);
      if (flush_req)
        while (bitq.size() % 8 != 0) bitq.push_back(1'b1);
      model_drain();
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_q();
    rx_q.delete();
    exp_q.delete();
    bitq.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    code_valid = 1'b0;
    flush_req = 1'b0;
    step();
    step();
    reset = 1'b0;
    clear_q();
  endtask

  task automatic send(input logic [15:0] b, input logic [7:0] l);
    int t;
    t = 0;
    code_valid = 1'b1;
    code_bits = b;
    code_len = l;
    while (!code_ready && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) chk("send_timeout", 32'(code_ready), 32'd1);
    step();
    code_valid = 1'b0;
  endtask

  task automatic flush();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (!flush_done && t < 300) begin
      step();
      t++;
    end
    chk(name, 32'(flush_done), 32'd1);
  endtask

  task automatic check_stream(input string name);
    chk({name, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_b%0d", name, i), 32'(rx_q[i]), 32'(exp_q[i]));
    clear_q();
  endtask

  initial begin
    int acc_n;
    bit inflight;
    logic [23:0] e;

    vecs[0] = '{16'h0005, 8'd3,  1, 24'hBF0000};
    vecs[1] = '{16'h0000, 8'd1,  1, 24'h7F0000};
    vecs[2] = '{16'h0001, 8'd1,  2, 24'hFF0000};
    vecs[3] = '{16'h00FF, 8'd8,  2, 24'hFF0000};
    vecs[4] = '{16'hABCD, 8'd16, 2, 24'hABCD00};
    vecs[5] = '{16'h1234, 8'd0,  0, 24'h000000};
    vecs[6] = '{16'hFFFF, 8'd17, 0, 24'h000000};
    vecs[7] = '{16'hFFF0, 8'd4,  1, 24'h0F0000};
    vecs[8] = '{16'h8001, 8'd16, 2, 24'h800100};
    vecs[9] = '{16'h007F, 8'd7,  2, 24'hFF0000};

    do_reset();
    chk("rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte_data", 32'(byte_data), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_err_len", 32'(err_len), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_code_ready", 32'(code_ready), 32'd1);

    // single code then flush, compared against fixed byte tables
    foreach (vecs[i]) begin
      do_reset();
      byte_ready = 1'b1;
      send(vecs[i].bits, vecs[i].len);
      flush();
      wait_done($sformatf("vec%0d_done", i));
      chk($sformatf("vec%0d_n", i), 32'(rx_q.size()), 32'(vecs[i].n));
      for (int j = 0; j < vecs[i].n && j < rx_q.size(); j++) begin
        e = vecs[i].exp << (8 * j);
        chk($sformatf("vec%0d_b%0d", i, j), 32'(rx_q[j]), 32'(e[23:16]));
      end
      clear_q();
    end

    // byte completed by the second code appears the following cycle
    do_reset();
    byte_ready = 1'b1;
    send(16'h0005, 8'd3);
    send(16'h001F, 8'd5);
    chk("pack_valid", 32'(byte_valid), 32'd1);
    chk("pack_data", 32'(byte_data), 32'hBF);
    chk("pack_busy", 32'(busy), 32'd1);
    step();
    chk("pack_valid_after", 32'(byte_valid), 32'd0);
    chk("pack_idle", 32'(busy), 32'd0);
    check_stream("pack");

    // stuffing on consecutive cycles, and none without STUFF_EN
    do_reset();
    byte_ready = 1'b1;
    send(16'h00FF, 8'd8);
    chk("stuff_ff", 32'(byte_data), 32'hFF);
    chk("nostuff_ff", 32'(n_byte_data), 32'hFF);
    chk("nostuff_valid", 32'(n_byte_valid), 32'd1);
    step();
    chk("stuff_00_valid", 32'(byte_valid), 32'd1);
    chk("stuff_00", 32'(byte_data), 32'h00);
    chk("nostuff_none", 32'(n_byte_valid), 32'd0);
    step();
    chk("stuff_end", 32'(byte_valid), 32'd0);
    check_stream("stuff");

    // flush with nothing buffered: flush_done on the third cycle, no bytes
    do_reset();
    byte_ready = 1'b1;
    flush();
    chk("fe_busy", 32'(busy), 32'd1);
    step();
    chk("fe_early", 32'(flush_done), 32'd0);
    step();
    chk("fe_done", 32'(flush_done), 32'd1);
    chk("fe_nobytes", 32'(rx_q.size()), 32'd0);
    step();
    chk("fe_pulse", 32'(flush_done), 32'd0);
    chk("fe_idle", 32'(busy), 32'd0);

    // backpressure: hold output, stall codes, then release with no gaps
    do_reset();
    byte_ready = 1'b0;
    code_valid = 1'b1;
    code_bits = 16'hABCD;
    code_len = 8'd16;
    acc_n = 0;
    for (int c = 0; c < 8; c++) begin
      if (code_valid && code_ready) acc_n++;
      step();
      if (c >= 1) begin
        chk("bp_hold", 32'(byte_data), 32'hAB);
        chk("bp_stall", 32'(code_ready), 32'd0);
      end
    end
    byte_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk("bp_nogap", 32'(byte_valid), 32'd1);
      if (code_valid && code_ready) acc_n++;
      step();
      if (acc_n == 3) code_valid = 1'b0;
    end
    chk("bp_drained", 32'(byte_valid), 32'd0);
    chk("bp_count", 32'(rx_q.size()), 32'd6);
    check_stream("bp");

    // length edge cases
    do_reset();
    byte_ready = 1'b1;
    send(16'h1234, 8'd0);
    step();
    chk("len0_idle", 32'(busy), 32'd0);
    chk("len0_err", 32'(err_len), 32'd0);
    send(16'hFFFF, 8'd17);
    step();
    chk("len17_err", 32'(err_len), 32'd1);
    chk("len17_idle", 32'(busy), 32'd0);
    send(16'hFFFF, 8'd16);
    repeat (6) step();
    chk("err_sticky", 32'(err_len), 32'd1);
    chk("len16_count", 32'(rx_q.size()), 32'd4);
    check_stream("len16");

    // reset mid-stream discards buffered bits and the pending byte
    do_reset();
    byte_ready = 1'b0;
    send(16'h0000, 8'd17);
    send(16'hABCD, 8'd16);
    send(16'h000F, 8'd4);
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_valid", 32'(byte_valid), 32'd0);
    chk("mid_busy_clr", 32'(busy), 32'd0);
    chk("mid_err_clr", 32'(err_len), 32'd0);
    clear_q();
    byte_ready = 1'b1;
    send(16'h00A5, 8'd8);
    repeat (3) step();
    chk("mid_count", 32'(rx_q.size()), 32'd1);
    check_stream("mid");

    // randomized traffic against the bit-queue model
    do_reset();
    inflight = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      code_valid = ($urandom_range(0, 9) < 7);
      code_bits = 16'($urandom);
      code_len = ($urandom_range(0, 49) == 0) ? 8'($urandom_range(17, 40)) : 8'($urandom_range(0, 16));
      byte_ready = ($urandom_range(0, 3) != 0);
      flush_req = !inflight && ($urandom_range(0, 59) == 0);
      if (flush_req) inflight = 1'b1;
      step();
      flush_req = 1'b0;
      if (flush_done) begin
        inflight = 1'b0;
        check_stream("rand_flush");
      end
    end
    code_valid = 1'b0;
    byte_ready = 1'b1;
    if (inflight) begin
      wait_done("rand_tail_done");
      step();
    end
    flush();
    wait_done("rand_final_done");
    check_stream("rand_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
